mac_product_accumulator: RTL

Downstream consumer of the 4x4 array multiplier's 8-bit product. Sums a programmed number of consecutive products into a saturating accumulator, forming a small dot-product/MAC stage. Products arrive on a valid/ready handshake. The finished sum is flagged with a one-cycle done pulse and held until the next run.

---
 rtl/mac_product_accumulator_if.sv | 27 ++
 rtl/mac_product_accumulator.sv | 87 ++++++++
 2 files changed

// File: rtl/mac_product_accumulator_if.sv
// Handshake and result bundle between a product source and the MAC accumulator.
// The master drives the run control and products; the slave returns the handshake and the result.
interface mac_product_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 4
);
    logic              start;
    logic [CNT_W-1:0]  len;
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              prod_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              done;
    logic              busy;
    logic              ovf;

    modport master (
        output start, len, prod_in, prod_valid,
        input  prod_ready, acc_out, done, busy, ovf
    );

    modport slave (
        input  start, len, prod_in, prod_valid,
        output prod_ready, acc_out, done, busy, ovf
    );
endinterface

// File: rtl/mac_product_accumulator.sv
// Sums a programmed number of multiplier products into a saturating accumulator.
// The finished sum is flagged by a one-cycle done pulse and held until the next run.
module mac_product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 4
) (
    input logic clk,
    input logic rst_n,
    mac_product_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              xfer;
    logic [ACC_W:0]    sum;

    // One extra bit of headroom exposes the carry that triggers saturation.
    assign xfer = (state_q == ACC) && bus.prod_valid;
    assign sum  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = bus.len;
                    state_d = (bus.len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (xfer) begin
                    if (sum[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.prod_ready = (state_q == ACC);
        bus.done       = (state_q == DONE);
        bus.busy       = (state_q == ACC) || (state_q == DONE);
        bus.acc_out    = acc_q;
        bus.ovf        = ovf_q;
    end
endmodule
